tmvp_operand_loader: RTL and testbench

Upstream operand stage for the two-level Toeplitz matrix-vector multiplier core. Accepts a Toeplitz matrix (first row, first column) and a vector over a single AXI-Stream slave and stores them in local banks. Serves the core's two row/column read ports and two vector read ports with fixed 1-cycle latency. Sequences the core's start/ready handshake, so one operand set is loaded per product.

---
 rtl/tmvp_operand_loader.sv | 165 ++++++++++++++++
 tb/tb_tmvp_operand_loader.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/tmvp_operand_loader.sv
// Operand loader for the Toeplitz matrix-vector core: streams row/col/vec banks in
// over AXI-Stream, serves registered read ports and sequences the core start handshake.
module tmvp_operand_loader #(
  parameter int N          = 32,
  parameter int DATA_WIDTH = 4,
  localparam int AW        = $clog2(N)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tvalid,
  input  logic                  s_axis_tlast,
  output logic                  s_axis_tready,
  input  logic [AW-1:0]         address_1,
  input  logic                  address_1_isRow,
  input  logic [AW-1:0]         address_2,
  input  logic                  address_2_isRow,
  input  logic                  address_row_valid,
  input  logic [AW-1:0]         address_vec_1,
  input  logic [AW-1:0]         address_vec_2,
  input  logic                  address_vec_valid,
  output logic [DATA_WIDTH-1:0] data_row_data_1,
  output logic [DATA_WIDTH-1:0] data_row_data_2,
  output logic                  data_row_valid,
  output logic [DATA_WIDTH-1:0] data_vec_data_1,
  output logic [DATA_WIDTH-1:0] data_vec_data_2,
  output logic                  data_vec_valid,
  output logic                  tmvp_start,
  input  logic                  tmvp_ready,
  output logic                  busy,
  output logic                  load_error
);

  typedef enum logic [2:0] {LOAD_ROW, LOAD_COL, LOAD_VEC, ARM, RUN} state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   cnt_q, cnt_d;
  logic            seen_busy_q, seen_busy_d;
  logic            tready_q, tready_d;
  logic            busy_q, busy_d;
  logic            start_q, start_d;
  logic            err_q, err_d;

  logic [DATA_WIDTH-1:0] row_mem [N];
  logic [DATA_WIDTH-1:0] col_mem [N];
  logic [DATA_WIDTH-1:0] vec_mem [N];

  logic [DATA_WIDTH-1:0] rd_row1_q, rd_row2_q, rd_vec1_q, rd_vec2_q;
  logic                  rd_row_valid_q, rd_vec_valid_q;

  logic accept;
  logic bank_last;
  logic set_last;

  // tready is registered, so an accept always happens in a LOAD state
  assign accept    = s_axis_tvalid && tready_q;
  assign bank_last = (cnt_q == AW'(N - 1));
  assign set_last  = (state_q == LOAD_VEC) && bank_last;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= LOAD_ROW;
      cnt_q       <= '0;
      seen_busy_q <= 1'b0;
      tready_q    <= 1'b0;
      busy_q      <= 1'b0;
      start_q     <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      seen_busy_q <= seen_busy_d;
      tready_q    <= tready_d;
      busy_q      <= busy_d;
      start_q     <= start_d;
      err_q       <= err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    seen_busy_d = seen_busy_q;
    case (state_q)
      LOAD_ROW, LOAD_COL, LOAD_VEC: begin
        if (accept) begin
          if (s_axis_tlast != set_last) begin
            state_d = LOAD_ROW;
            cnt_d   = '0;
          end else if (bank_last) begin
            cnt_d = '0;
            case (state_q)
              LOAD_ROW: state_d = LOAD_COL;
              LOAD_COL: state_d = LOAD_VEC;
              default:  state_d = ARM;
            endcase
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      ARM: begin
        if (tmvp_ready) state_d = RUN;
      end
      RUN: begin
        // core must be seen busy before its ready is taken as completion
        if (!tmvp_ready) begin
          seen_busy_d = 1'b1;
        end else if (seen_busy_q) begin
          seen_busy_d = 1'b0;
          state_d     = LOAD_ROW;
        end
      end
      default: state_d = LOAD_ROW;
    endcase
  end

  always_comb begin
    tready_d = (state_d == LOAD_ROW) || (state_d == LOAD_COL) || (state_d == LOAD_VEC);
    busy_d   = (state_d == ARM) || (state_d == RUN);
    start_d  = (state_q == ARM) && tmvp_ready;
    err_d    = accept && (s_axis_tlast != set_last);
  end

  always_ff @(posedge clk) begin
    if (reset && accept) begin
      case (state_q)
        LOAD_ROW: row_mem[cnt_q] <= s_axis_tdata;
        LOAD_COL: col_mem[cnt_q] <= s_axis_tdata;
        LOAD_VEC: vec_mem[cnt_q] <= s_axis_tdata;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      rd_row1_q      <= '0;
      rd_row2_q      <= '0;
      rd_vec1_q      <= '0;
      rd_vec2_q      <= '0;
      rd_row_valid_q <= 1'b0;
      rd_vec_valid_q <= 1'b0;
    end else begin
      rd_row1_q      <= address_1_isRow ? row_mem[address_1] : col_mem[address_1];
      rd_row2_q      <= address_2_isRow ? row_mem[address_2] : col_mem[address_2];
      rd_vec1_q      <= vec_mem[address_vec_1];
      rd_vec2_q      <= vec_mem[address_vec_2];
      rd_row_valid_q <= address_row_valid;
      rd_vec_valid_q <= address_vec_valid || address_row_valid;
    end
  end

  assign s_axis_tready   = tready_q;
  assign busy            = busy_q;
  assign tmvp_start      = start_q;
  assign load_error      = err_q;
  assign data_row_data_1 = rd_row1_q;
  assign data_row_data_2 = rd_row2_q;
  assign data_row_valid  = rd_row_valid_q;
  assign data_vec_data_1 = rd_vec1_q;
  assign data_vec_data_2 = rd_vec2_q;
  assign data_vec_valid  = rd_vec_valid_q;

endmodule

// File: tb/tb_tmvp_operand_loader.sv
// Scoreboard bench for tmvp_operand_loader: directed operand sets, reads checked by a monitor.
module tb_tmvp_operand_loader;
  localparam int N  = 32;
  localparam int DW = 4;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          reset;
  logic [DW-1:0] s_axis_tdata;
  logic          s_axis_tvalid, s_axis_tlast, s_axis_tready;
  logic [AW-1:0] address_1, address_2, address_vec_1, address_vec_2;
  logic          address_1_isRow, address_2_isRow, address_row_valid, address_vec_valid;
  logic [DW-1:0] data_row_data_1, data_row_data_2, data_vec_data_1, data_vec_data_2;
  logic          data_row_valid, data_vec_valid;
  logic          tmvp_start, tmvp_ready, busy, load_error;

  tmvp_operand_loader #(.N(N), .DATA_WIDTH(DW)) dut (
    .clk(clk), .reset(reset),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tlast(s_axis_tlast), .s_axis_tready(s_axis_tready),
    .address_1(address_1), .address_1_isRow(address_1_isRow),
    .address_2(address_2), .address_2_isRow(address_2_isRow),
    .address_row_valid(address_row_valid),
    .address_vec_1(address_vec_1), .address_vec_2(address_vec_2),
    .address_vec_valid(address_vec_valid),
    .data_row_data_1(data_row_data_1), .data_row_data_2(data_row_data_2),
    .data_row_valid(data_row_valid),
    .data_vec_data_1(data_vec_data_1), .data_vec_data_2(data_vec_data_2),
    .data_vec_valid(data_vec_valid),
    .tmvp_start(tmvp_start), .tmvp_ready(tmvp_ready),
    .busy(busy), .load_error(load_error)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] d1;
    logic [DW-1:0] d2;
    string         nm;
  } exp_t;

  exp_t row_q[$];
  exp_t vec_q[$];
  exp_t mon_e;

  int passed = 0;
  int total = 0;
  int start_cnt = 0;
  int err_cnt = 0;

  logic [DW-1:0] m_row[N];
  logic [DW-1:0] m_col[N];
  logic [DW-1:0] m_vec[N];

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    else passed++;
  endtask

  task automatic tick(int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Monitor: counts control pulses and pops the scoreboard on every valid read beat.
  always @(negedge clk) begin
    if (tmvp_start) start_cnt++;
    if (load_error) err_cnt++;
    if (data_row_valid) begin
      if (row_q.size() == 0) chk("row_unexpected", 32'd1, 32'd0);
      else begin
        mon_e = row_q.pop_front();
        chk({mon_e.nm, "_d1"}, 32'(data_row_data_1), 32'(mon_e.d1));
        chk({mon_e.nm, "_d2"}, 32'(data_row_data_2), 32'(mon_e.d2));
      end
    end
    if (data_vec_valid) begin
      if (vec_q.size() == 0) chk("vec_unexpected", 32'd1, 32'd0);
      else begin
        mon_e = vec_q.pop_front();
        chk({mon_e.nm, "_v1"}, 32'(data_vec_data_1), 32'(mon_e.d1));
        chk({mon_e.nm, "_v2"}, 32'(data_vec_data_2), 32'(mon_e.d2));
      end
    end
  end

  task automatic send_word(logic [DW-1:0] d, logic last, output bit ok);
    s_axis_tdata  = d;
    s_axis_tvalid = 1'b1;
    s_axis_tlast  = last;
    ok = 1'b0;
    for (int t = 0; t < 200; t++) begin
      @(negedge clk);
      if (s_axis_tready) begin
        @(posedge clk);
        #1;
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk("tready_timeout", 32'd0, 32'd1);
  endtask

  // Sends words 0..stop_at of variant v; tlast only on word tlast_at (-1 = never).
  task automatic send_set(int v, int stop_at, int tlast_at);
    bit ok;
    int idx;
    int bank;
    logic [DW-1:0] d;
    for (int w = 0; w <= stop_at; w++) begin
      idx  = w % N;
      bank = w / N;
      if (bank == 0)      d = 4'((idx + v) % 8);
      else if (bank == 1) d = 4'(-((idx + v) % 8));
      else                d = 4'(idx + v);
      send_word(d, (w == tlast_at), ok);
      if (!ok) break;
    end
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    if (stop_at == 3*N-1 && tlast_at == 3*N-1) begin
      for (int i = 0; i < N; i++) begin
        m_row[i] = 4'((i + v) % 8);
        m_col[i] = 4'(-((i + v) % 8));
        m_vec[i] = 4'(i + v);
      end
    end
  endtask

  task automatic read_row(logic [AW-1:0] a1, logic r1, logic [AW-1:0] a2, logic r2,
                          logic [DW-1:0] e1, logic [DW-1:0] e2, string nm);
    address_1 = a1; address_1_isRow = r1;
    address_2 = a2; address_2_isRow = r2;
    address_row_valid = 1'b1;
    row_q.push_back('{e1, e2, nm});
    vec_q.push_back('{m_vec[address_vec_1], m_vec[address_vec_2], {nm, "_vec"}});
    tick();
    address_row_valid = 1'b0;
  endtask

  task automatic read_vec(logic [AW-1:0] a1, logic [AW-1:0] a2,
                          logic [DW-1:0] e1, logic [DW-1:0] e2, string nm);
    address_vec_1 = a1; address_vec_2 = a2;
    address_vec_valid = 1'b1;
    vec_q.push_back('{e1, e2, nm});
    tick();
    address_vec_valid = 1'b0;
  endtask

  task automatic finish_run();
    tmvp_ready = 1'b0;
    tick(3);
    tmvp_ready = 1'b1;
    tick(2);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $display("%0d/%0d checks passed", passed, total + 1);
    $fatal(1);
  end

  initial begin
    reset = 1'b0; tmvp_ready = 1'b1;
    s_axis_tdata = '0; s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0;
    address_1 = '0; address_2 = '0; address_1_isRow = 1'b0; address_2_isRow = 1'b0;
    address_row_valid = 1'b0; address_vec_1 = '0; address_vec_2 = '0; address_vec_valid = 1'b0;
    for (int i = 0; i < N; i++) begin m_row[i] = '0; m_col[i] = '0; m_vec[i] = '0; end
    tick(3);
    chk("rst_tready", 32'(s_axis_tready), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_start", 32'(tmvp_start), 32'd0);
    chk("rst_err", 32'(load_error), 32'd0);
    chk("rst_rvalid", 32'(data_row_valid), 32'd0);
    chk("rst_vvalid", 32'(data_vec_valid), 32'd0);
    chk("rst_rdata", {24'd0, data_row_data_1, data_row_data_2}, 32'd0);
    chk("rst_vdata", {24'd0, data_vec_data_1, data_vec_data_2}, 32'd0);
    reset = 1'b1;
    chk("post_rst_tready_low", 32'(s_axis_tready), 32'd0);
    tick();
    chk("post_rst_tready_high", 32'(s_axis_tready), 32'd1);

    // 1: clean set, core ready
    send_set(0, 3*N-1, 3*N-1);
    chk("t1_tready_low", 32'(s_axis_tready), 32'd0);
    chk("t1_busy", 32'(busy), 32'd1);
    tick(4);
    chk("t1_start_once", 32'(start_cnt), 32'd1);
    chk("t1_busy_run", 32'(busy), 32'd1);
    chk("t1_no_err", 32'(err_cnt), 32'd0);

    // 2/3: reads, including same-entry and bank-mix cases
    read_row(5'd5, 1'b1, 5'd3, 1'b0, 4'd5, 4'hD, "t2_row");
    read_vec(5'd31, 5'd0, 4'hF, 4'h0, "t3_vec");
    read_row(5'd7, 1'b1, 5'd7, 1'b1, 4'd7, 4'd7, "same_row");
    read_row(5'd9, 1'b0, 5'd9, 1'b1, 4'hF, 4'd1, "mix_addr");
    read_vec(5'd17, 5'd17, 4'd1, 4'd1, "same_vec");
    read_row(5'd31, 1'b0, 5'd0, 1'b1, 4'h9, 4'd0, "edge_row");
    finish_run();
    chk("t1_release_tready", 32'(s_axis_tready), 32'd1);
    chk("t1_release_busy", 32'(busy), 32'd0);

    // 4: early tlast aborts, then a clean set
    send_set(1, 40, 40);
    chk("t4_err_pulse", 32'(load_error), 32'd1);
    chk("t4_tready", 32'(s_axis_tready), 32'd1);
    tick();
    chk("t4_err_one_cycle", 32'(load_error), 32'd0);
    chk("t4_err_cnt", 32'(err_cnt), 32'd1);
    send_set(1, 3*N-1, 3*N-1);
    tick(4);
    chk("t4_start", 32'(start_cnt), 32'd2);
    read_row(5'd2, 1'b1, 5'd2, 1'b0, 4'd3, 4'hD, "t4_row");
    finish_run();

    // missing tlast on the final word aborts as well
    send_set(2, 3*N-1, -1);
    chk("nolast_err", 32'(load_error), 32'd1);
    chk("nolast_tready", 32'(s_axis_tready), 32'd1);
    chk("nolast_busy", 32'(busy), 32'd0);
    tick(3);
    chk("nolast_no_start", 32'(start_cnt), 32'd2);
    chk("nolast_err_cnt", 32'(err_cnt), 32'd2);

    // 5: core not ready during ARM
    tmvp_ready = 1'b0;
    send_set(2, 3*N-1, 3*N-1);
    tick(10);
    chk("t5_no_start", 32'(start_cnt), 32'd2);
    chk("t5_busy", 32'(busy), 32'd1);
    tmvp_ready = 1'b1;
    tick(3);
    chk("t5_start", 32'(start_cnt), 32'd3);
    read_row(5'd4, 1'b1, 5'd4, 1'b0, 4'd6, 4'hA, "t5_row");
    tick(5);
    chk("t5_run_hold", 32'(s_axis_tready), 32'd0);
    finish_run();
    chk("t5_release", 32'(s_axis_tready), 32'd1);

    // 6: reset mid-load
    send_set(3, 49, -1);
    reset = 1'b0;
    tick();
    chk("t6_rst_tready", 32'(s_axis_tready), 32'd0);
    chk("t6_rst_data", {24'd0, data_row_data_1, data_row_data_2}, 32'd0);
    chk("t6_rst_vdata", {24'd0, data_vec_data_1, data_vec_data_2}, 32'd0);
    tick();
    reset = 1'b1;
    tick();
    chk("t6_tready", 32'(s_axis_tready), 32'd1);
    chk("t6_no_start", 32'(start_cnt), 32'd3);
    send_set(3, 3*N-1, 3*N-1);
    tick(4);
    chk("t6_start", 32'(start_cnt), 32'd4);
    read_row(5'd0, 1'b1, 5'd0, 1'b0, 4'd3, 4'hD, "t6_row0");
    read_vec(5'd0, 5'd5, 4'd3, 4'd8, "t6_vec");
    finish_run();

    tick(3);
    chk("row_q_drained", 32'(row_q.size()), 32'd0);
    chk("vec_q_drained", 32'(vec_q.size()), 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
